// File: rtl/otp_pkg.sv
// Shared widths, limits and digit helpers for the OTP entry front end.
package otp_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned POS_W      = 2;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // System clock rate; timing defaults are derived from it.
    localparam int unsigned CLK_HZ = 100_000_000;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Modulo-10 increment: 9 wraps to 0.
    function automatic digit_t digit_inc(input digit_t d);
        return (d >= DIGIT_MAX) ? '0 : d + DIGIT_W'(1);
    endfunction

    // Modulo-10 decrement: 0 wraps to 9.
    function automatic digit_t digit_dec(input digit_t d);
        return (d == '0) ? DIGIT_MAX : d - DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/otp_digit_entry_button_conditioner.sv
// One push-button path: 2-flop synchronizer, debouncer, press-edge pulse
// and optional hold-to-repeat. press_o carries both press and repeat steps.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic btn_i,
    output logic press_o,
    output logic db_o
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             db_prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             press_q, press_d;
    logic             armed_q, armed_d;
    logic             rpting_q, rpting_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rise;
    logic             rpt_fire;

    // Debounce, edge detect and repeat scheduling.
    always_comb begin
        db_d      = db_q;
        db_cnt_d  = '0;
        armed_d   = armed_q;
        rpting_d  = rpting_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;

        // Accept a level change only after DEBOUNCE_CYCLES consecutive mismatches.
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        rise = db_q & ~db_prev_q;

        // clear disarms a held button so only a fresh press can fire again.
        if (clear_i || !db_q) begin
            armed_d   = 1'b0;
            rpting_d  = 1'b0;
            rpt_cnt_d = '0;
        end else if (rise) begin
            armed_d   = REPEAT_EN;
            rpting_d  = 1'b0;
            rpt_cnt_d = '0;
        end else if (armed_q) begin
            if (rpt_cnt_q == (rpting_q ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_fire  = 1'b1;
                rpting_d  = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end

        press_d = ~clear_i & (rise | rpt_fire);
    end

    // State registers; synchronizer, debounce, edge and repeat all clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            armed_q   <= 1'b0;
            rpting_q  <= 1'b0;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            armed_q   <= armed_d;
            rpting_q  <= rpting_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign press_o = press_q;
    assign db_o    = db_q;

endmodule

// File: rtl/otp_digit_entry.sv
// Button-driven BCD digit entry feeding the OTP authentication FSM.
module otp_digit_entry
    import otp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 50,
    parameter int unsigned REPEAT_DELAY    = CLK_HZ / 2,
    parameter int unsigned REPEAT_PERIOD   = CLK_HZ / 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_enter,
    input  logic               clear,
    output logic [DIGIT_W-1:0] user_digit,
    output logic               user_latch,
    output logic [DIGIT_W-1:0] cur_digit,
    output logic [POS_W-1:0]   digit_pos
);

    logic inc_p, dec_p, enter_p;
    logic inc_db, dec_db, enter_db;
    logic unused_db;

    digit_t           cur_q, cur_d;
    digit_t           user_digit_q, user_digit_d;
    logic             user_latch_q, user_latch_d;
    logic [POS_W-1:0] pos_q, pos_d;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_inc (
        .clk(clk), .reset(reset), .clear_i(clear), .btn_i(btn_inc),
        .press_o(inc_p), .db_o(inc_db)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
    ) u_dec (
        .clk(clk), .reset(reset), .clear_i(clear), .btn_i(btn_dec),
        .press_o(dec_p), .db_o(dec_db)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
    ) u_enter (
        .clk(clk), .reset(reset), .clear_i(clear), .btn_i(btn_enter),
        .press_o(enter_p), .db_o(enter_db)
    );

    // The datapath acts on press pulses only; debounced levels are not needed here.
    assign unused_db = inc_db ^ dec_db ^ enter_db;

    // Event priority: clear, then enter, then a lone inc or dec step.
    always_comb begin
        cur_d        = cur_q;
        pos_d        = pos_q;
        user_digit_d = user_digit_q;
        user_latch_d = 1'b0;
        if (clear) begin
            cur_d = '0;
            pos_d = '0;
        end else if (enter_p) begin
            user_digit_d = cur_q;
            user_latch_d = 1'b1;
            cur_d        = '0;
            pos_d        = pos_q + POS_W'(1);
        end else if (inc_p && !dec_p) begin
            cur_d = digit_inc(cur_q);
        end else if (dec_p && !inc_p) begin
            cur_d = digit_dec(cur_q);
        end
    end

    // Digit, position and latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q        <= '0;
            pos_q        <= '0;
            user_digit_q <= '0;
            user_latch_q <= 1'b0;
        end else begin
            cur_q        <= cur_d;
            pos_q        <= pos_d;
            user_digit_q <= user_digit_d;
            user_latch_q <= user_latch_d;
        end
    end

    assign cur_digit  = cur_q;
    assign digit_pos  = pos_q;
    assign user_digit = user_digit_q;
    assign user_latch = user_latch_q;

endmodule
